// File: rtl/adaptive_phase_controller_pkg.sv
// tc_pkg: phase encoding and green-time helpers shared by the adaptive phase controller
package tc_pkg;
   typedef enum logic [2:0] {G_SR = 3'd0, G_S = 3'd1, YEL = 3'd2, ALL_RED = 3'd3, EMG = 3'd4} phase_t;
   typedef struct packed {
      logic [31:0] sr;
      logic [31:0] s;
   } split_t;
   function automatic int level_to_total(input logic [1:0] lvl, input int t0, input int t1, input int t2, input int t3);
      return lvl == 2'd0 ? t0 : lvl == 2'd1 ? t1 : lvl == 2'd2 ? t2 : t3;
   endfunction
   // straight+right gets 70% of the total green, product formed at twice the counter width
   function automatic split_t split(input int tot, input int cnt_w);
      logic [63:0] p;
      split_t r;
      p = (64'(tot) * 64'd7) & ((64'd1 << (2 * cnt_w)) - 64'd1);
      r.sr = 32'(p / 64'd10);
      r.s = 32'(tot) - r.sr;
      return r;
   endfunction
endpackage

// File: rtl/adaptive_phase_controller_timer.sv
// phase_timer: down-counter giving cycles left in the current phase
//   load/load_val : start a phase with duration-1
//   hold          : freeze the count (emergency hold)
//   count, zero   : cycles left minus one, and last-cycle flag
module phase_timer #(
   parameter int CNT_W    = 8,
   parameter int ALLRED_T = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             hold,
   output logic [CNT_W-1:0] count,
   output logic             zero
);
   assign zero = count == '0;
   always_ff @(posedge clk or posedge reset)
      if (reset) count <= CNT_W'(ALLRED_T - 1);
      else if (load) count <= load_val;
      else if (!hold && !zero) count <= count - 1'b1;
endmodule

// File: rtl/adaptive_phase_controller.sv
// adaptive_phase_controller: N-approach round-robin signal controller with congestion-scaled green and emergency preemption
//   sensor  : 2-bit congestion level per approach, approach d on [2d+1:2d]
//   emg_req/emg_dir : level-sensitive preemption request and target approach
//   red/yellow/green_s/green_r : per-approach lamps
//   cur_dir/phase/remaining/emg_active : served approach, phase code, cycles left minus one, emergency flag
module adaptive_phase_controller
   import tc_pkg::*;
#(
   parameter int  NUM_DIR    = 4,
   parameter int  CNT_W      = 8,
   parameter int  T_LVL0     = 30,
   parameter int  T_LVL1     = 45,
   parameter int  T_LVL2     = 70,
   parameter int  T_LVL3     = 100,
   parameter int  YELLOW_T   = 5,
   parameter int  ALLRED_T   = 2,
   parameter int  SKIP_EMPTY = 1,
   localparam int DIR_W      = $clog2(NUM_DIR)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [2*NUM_DIR-1:0] sensor,
   input  logic                 emg_req,
   input  logic [DIR_W-1:0]     emg_dir,
   output logic [NUM_DIR-1:0]   red,
   output logic [NUM_DIR-1:0]   yellow,
   output logic [NUM_DIR-1:0]   green_s,
   output logic [NUM_DIR-1:0]   green_r,
   output logic [DIR_W-1:0]     cur_dir,
   output logic [2:0]           phase,
   output logic [CNT_W-1:0]     remaining,
   output logic                 emg_active
);
   phase_t state, nxt_state;
   logic [DIR_W-1:0] edir, nxt_edir, sel_dir, go_dir, nxt_dir;
   logic [CNT_W-1:0] count, load_val, s_len, nxt_s_len, sr_len, sg_len;
   logic [NUM_DIR-1:0] sel;
   logic pend, nxt_pend, emg_ok, emg_now, load, zero;
   split_t sp;
   function automatic logic [CNT_W-1:0] at_least_one(input logic [31:0] v);
      logic [CNT_W-1:0] t;
      t = CNT_W'(v);
      return t == '0 ? CNT_W'(1) : t;
   endfunction
   phase_timer #(.CNT_W(CNT_W), .ALLRED_T(ALLRED_T)) u_timer (
      .clk(clk), .reset(reset), .load(load), .load_val(load_val),
      .hold(state == EMG), .count(count), .zero(zero)
   );
   // nearest approach after cur_dir with demand; cur_dir itself is the last candidate
   always_comb begin
      sel_dir = DIR_W'((int'(cur_dir) + 1) % NUM_DIR);
      if (SKIP_EMPTY != 0)
         for (int k = NUM_DIR; k >= 1; k--)
            if (sensor[2*((int'(cur_dir) + k) % NUM_DIR) +: 2] != 2'b00) sel_dir = DIR_W'((int'(cur_dir) + k) % NUM_DIR);
   end
   assign sp = split(level_to_total(sensor[2*int'(sel_dir) +: 2], T_LVL0, T_LVL1, T_LVL2, T_LVL3), CNT_W);
   assign sr_len = at_least_one(sp.sr);
   assign sg_len = at_least_one(sp.s);
   assign emg_ok = emg_req && (int'(emg_dir) < NUM_DIR);
   // once a preemption is pending its target is frozen; it stays pending only while the request holds
   assign emg_now = pend ? emg_req : emg_ok;
   assign go_dir = pend ? edir : emg_dir;
   always_comb begin
      nxt_state = state;
      nxt_dir = cur_dir;
      nxt_pend = pend;
      nxt_edir = edir;
      nxt_s_len = s_len;
      load = 1'b0;
      load_val = '0;
      case (state)
         G_SR, G_S: begin
            if (emg_ok && emg_dir == cur_dir) begin
               nxt_state = EMG;
               load = 1'b1;
            end else if (emg_ok) begin
               nxt_state = YEL;
               nxt_pend = 1'b1;
               nxt_edir = emg_dir;
               load = 1'b1;
               load_val = CNT_W'(YELLOW_T - 1);
            end else if (zero) begin
               nxt_state = state == G_SR ? G_S : YEL;
               load = 1'b1;
               load_val = state == G_SR ? s_len - 1'b1 : CNT_W'(YELLOW_T - 1);
            end
         end
         YEL: begin
            nxt_pend = emg_now;
            nxt_edir = go_dir;
            if (zero) begin
               nxt_state = ALL_RED;
               load = 1'b1;
               load_val = CNT_W'(ALLRED_T - 1);
            end
         end
         ALL_RED: begin
            nxt_pend = emg_now;
            nxt_edir = go_dir;
            if (zero && emg_now) begin
               nxt_state = EMG;
               nxt_dir = go_dir;
               nxt_pend = 1'b0;
               load = 1'b1;
            end else if (zero) begin
               nxt_state = G_SR;
               nxt_dir = sel_dir;
               nxt_s_len = sg_len;
               load = 1'b1;
               load_val = sr_len - 1'b1;
            end
         end
         EMG: begin
            if (!emg_req) begin
               nxt_state = YEL;
               load = 1'b1;
               load_val = CNT_W'(YELLOW_T - 1);
            end
         end
         default: begin
            nxt_state = ALL_RED;
            load = 1'b1;
            load_val = CNT_W'(ALLRED_T - 1);
         end
      endcase
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= ALL_RED;
         cur_dir <= DIR_W'(NUM_DIR - 1);
         pend <= 1'b0;
         edir <= '0;
         s_len <= CNT_W'(1);
      end else begin
         state <= nxt_state;
         cur_dir <= nxt_dir;
         pend <= nxt_pend;
         edir <= nxt_edir;
         s_len <= nxt_s_len;
      end
   assign sel = {{(NUM_DIR-1){1'b0}}, 1'b1} << cur_dir;
   assign red = state == ALL_RED ? '1 : ~sel;
   assign yellow = state == YEL ? sel : '0;
   assign green_s = (state == G_SR || state == G_S || state == EMG) ? sel : '0;
   assign green_r = (state == G_SR || state == EMG) ? sel : '0;
   assign phase = state;
   assign remaining = count;
   assign emg_active = state == EMG;
endmodule

// File: tb/tb_adaptive_phase_controller.sv
// tb_adaptive_phase_controller: randomized scoreboard bench against a phase-level reference model
module tb_adaptive_phase_controller;
   localparam int N  = 6;
   localparam int DW = $clog2(N);
   localparam int SW = 2 * N;
   localparam int CW = 8;
   localparam int YT = 5;
   localparam int AT = 2;
   localparam int VW = 3 + DW + CW + 4 * N + 1;
   localparam int TL [4] = '{30, 45, 70, 100};

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [SW-1:0] sensor = '0;
   logic emg_req = 1'b0;
   logic [DW-1:0] emg_dir = '0;
   logic [N-1:0] red, yellow, green_s, green_r;
   logic [DW-1:0] cur_dir;
   logic [2:0] phase;
   logic [CW-1:0] remaining;
   logic emg_active;

   always #5 clk = ~clk;

   adaptive_phase_controller #(.NUM_DIR(N)) dut (
      .clk(clk), .reset(reset), .sensor(sensor), .emg_req(emg_req), .emg_dir(emg_dir),
      .red(red), .yellow(yellow), .green_s(green_s), .green_r(green_r),
      .cur_dir(cur_dir), .phase(phase), .remaining(remaining), .emg_active(emg_active)
   );

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      int ph;
      int dir;
      int rem;
   } exp_t;
   exp_t q[$];

   // reference model: current phase, its approach, its length and cycles spent in it
   int m_ph = 3, m_dir = N - 1, m_el = 0, m_dur = AT, m_slen = 1, m_pend = 0, m_edir = 0;

   function automatic int lvl_of(input logic [SW-1:0] s, input int d);
      logic [SW-1:0] t;
      t = s >> (2 * d);
      return int'(t[1:0]);
   endfunction

   function automatic int next_dir(input logic [SW-1:0] s, input int from);
      for (int k = 1; k <= N; k++)
         if (lvl_of(s, (from + k) % N) != 0) return (from + k) % N;
      return (from + 1) % N;
   endfunction

   task automatic enter(input int ph, input int dir, input int dur);
      m_ph = ph;
      m_dir = dir;
      m_dur = dur;
      m_el = 0;
   endtask

   task automatic model(input logic rst, input logic [SW-1:0] s, input logic req, input int ed);
      int valid, now, tgt, last, nd, tot, sr;
      if (rst) begin
         enter(3, N - 1, AT);
         m_pend = 0;
         return;
      end
      last = (m_el == m_dur - 1);
      valid = (req && ed < N) ? 1 : 0;
      now = m_pend != 0 ? int'(req) : valid;
      tgt = m_pend != 0 ? m_edir : ed;
      m_el++;
      case (m_ph)
         0, 1: begin
            if (valid != 0 && ed == m_dir) enter(4, m_dir, 1);
            else if (valid != 0) begin
               m_pend = 1;
               m_edir = ed;
               enter(2, m_dir, YT);
            end else if (last != 0) begin
               if (m_ph == 0) enter(1, m_dir, m_slen);
               else enter(2, m_dir, YT);
            end
         end
         2: begin
            m_pend = now;
            m_edir = tgt;
            if (last != 0) enter(3, m_dir, AT);
         end
         3: begin
            if (last != 0 && now != 0) begin
               enter(4, tgt, 1);
               m_pend = 0;
            end else if (last != 0) begin
               nd = next_dir(s, m_dir);
               tot = TL[lvl_of(s, nd)];
               sr = tot * 7 / 10;
               enter(0, nd, sr < 1 ? 1 : sr);
               m_slen = (tot - sr) < 1 ? 1 : tot - sr;
               m_pend = 0;
            end else begin
               m_pend = now;
               m_edir = tgt;
            end
         end
         default: if (!req) enter(2, m_dir, YT);
      endcase
   endtask

   function automatic logic [VW-1:0] expect_vec(input exp_t e);
      logic [N-1:0] one, r, y, gs, gr;
      one = '0;
      one[e.dir] = 1'b1;
      r = e.ph == 3 ? '1 : ~one;
      y = e.ph == 2 ? one : '0;
      gs = (e.ph == 0 || e.ph == 1 || e.ph == 4) ? one : '0;
      gr = (e.ph == 0 || e.ph == 4) ? one : '0;
      return {3'(e.ph), DW'(e.dir), CW'(e.rem), r, y, gs, gr, e.ph == 4};
   endfunction

   // monitor: one expected state per clock, compared just after the edge
   exp_t me;
   logic [VW-1:0] got, want;
   always @(posedge clk) begin
      #1;
      if (q.size() > 0) begin
         me = q.pop_front();
         got = {phase, cur_dir, remaining, red, yellow, green_s, green_r, emg_active};
         want = expect_vec(me);
         vectors++;
         if (got !== want) begin
            miscompares++;
            $display("FAIL state t=%0t got ph=%0d dir=%0d rem=%0d r=%b y=%b gs=%b gr=%b emg=%b, expected ph=%0d dir=%0d rem=%0d lamps=%b",
                     $time, phase, cur_dir, remaining, red, yellow, green_s, green_r, emg_active, me.ph, me.dir, me.rem, want[4*N:0]);
         end
         vectors++;
         if ($countones(~red) > 1) begin
            miscompares++;
            $display("FAIL one_nonred t=%0t red=%b, required at most one approach non-red", $time, red);
         end
      end
   end

   logic [SW-1:0] cs = '0;
   logic creq = 1'b0;
   logic [DW-1:0] ced = '0;

   task automatic step(input logic rst);
      exp_t e;
      @(negedge clk);
      if (rst && !reset) begin
         reset = 1'b1;
         #1;
         vectors++;
         if (phase !== 3'd3 || cur_dir !== DW'(N - 1) || remaining !== CW'(AT - 1) || red !== '1 ||
             yellow !== '0 || green_s !== '0 || green_r !== '0 || emg_active !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset got ph=%0d dir=%0d rem=%0d red=%b y=%b gs=%b gr=%b, required ph=3 dir=%0d rem=%0d all red",
                     phase, cur_dir, remaining, red, yellow, green_s, green_r, N - 1, AT - 1);
         end
      end
      reset = rst;
      sensor = cs;
      emg_req = creq;
      emg_dir = ced;
      model(rst, cs, creq, int'(ced));
      e.ph = m_ph;
      e.dir = m_dir;
      e.rem = m_ph == 4 ? 0 : m_dur - 1 - m_el;
      q.push_back(e);
   endtask

   task automatic run(input int n);
      repeat (n) step(1'b0);
   endtask

   task automatic wait_model(input int ph, input int dir, input int el, input int budget, input string tag);
      int ok;
      ok = 0;
      for (int i = 0; i < budget && ok == 0; i++) begin
         step(1'b0);
         ok = (m_ph == ph && (dir < 0 || m_dir == dir) && (el < 0 || m_el == el)) ? 1 : 0;
      end
      if (ok == 0) begin
         vectors++;
         miscompares++;
         $display("FAIL wait_%s phase %0d not reached within %0d cycles, now ph=%0d dir=%0d", tag, ph, budget, m_ph, m_dir);
      end
   endtask

   task automatic rand_levels();
      for (int d = 0; d < N; d++) cs[2*d +: 2] = 2'($urandom_range(1, 3));
   endtask

   initial begin
      // all approaches at level 3
      cs = '1;
      repeat (3) step(1'b1);
      run(125);
      // sparse demand on approaches 0 and 3
      cs = '0;
      cs[1:0] = 2'd1;
      cs[7:6] = 2'd2;
      repeat (2) step(1'b1);
      run(200);
      // no demand anywhere: plain round-robin including the wrap
      cs = '0;
      repeat (2) step(1'b1);
      run(240);
      // preempt to approach 2 from cycle 10 of approach 0 green
      rand_levels();
      repeat (2) step(1'b1);
      wait_model(0, 0, 10, 50, "g0");
      creq = 1'b1;
      ced = DW'(2);
      run(40);
      creq = 1'b0;
      run(30);
      // preempt to the approach already served while in G_S
      wait_model(1, -1, -1, 300, "gs");
      creq = 1'b1;
      ced = DW'(m_dir);
      run(12);
      creq = 1'b0;
      run(20);
      // out-of-range targets must be ignored
      creq = 1'b1;
      ced = DW'(7);
      run(150);
      ced = DW'(6);
      run(150);
      creq = 1'b0;
      // random traffic and preemption
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 19) == 0) cs = SW'($urandom);
         if ($urandom_range(0, 49) == 0) creq = ~creq;
         if ($urandom_range(0, 29) == 0) ced = DW'($urandom_range(0, 7));
         step(1'b0);
      end
      creq = 1'b0;
      cs = '1;
      // asynchronous reset while yellow
      wait_model(2, -1, 2, 400, "yel");
      repeat (2) step(1'b1);
      run(20);
      @(posedge clk);
      #2;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
